mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_streak.sv | 33 +++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: state encoding and
// parameter defaults.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned MAX_STREAK_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_streak.sv
// Counts consecutive data grants made while a fetch is waiting; flags when the
// fetch port must be given the next grant.
module mem_arb_streak
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_grant_d,
    input  logic i_grant_i,
    input  logic i_ireq,
    output logic o_at_max
);

    localparam int unsigned CNT_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);

    logic [CNT_W-1:0] r_count;

    // The forced fetch grant at the limit clears the count, so it never exceeds MAX_STREAK.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_grant_i || (i_grant_d && !i_ireq)) begin
            r_count <= '0;
        end else if (i_grant_d) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_max = (r_count == CNT_W'(MAX_STREAK));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory port, data has fixed priority.
// Define ARB_FAIRNESS_EN to bound data streaks while a fetch waits.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [DATA_W-1:0] IRdata,
    output logic              IDone,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWdata,
    output logic [DATA_W-1:0] DRdata,
    output logic              DDone,
    output logic              MReq,
    output logic              MWe,
    output logic [ADDR_W-1:0] MAddr,
    output logic [DATA_W-1:0] MWdata,
    input  logic [DATA_W-1:0] MRdata,
    input  logic              MAck
);

    arb_state_e        r_state;
    logic              r_mreq;
    logic              r_mwe;
    logic [ADDR_W-1:0] r_maddr;
    logic [DATA_W-1:0] r_mwdata;
    logic [DATA_W-1:0] r_irdata;
    logic [DATA_W-1:0] r_drdata;

    logic w_idle;
    logic w_force_i;
    logic w_grant_d;
    logic w_grant_i;

    assign w_idle = (r_state == IDLE);

`ifdef ARB_FAIRNESS_EN
    logic w_at_max;

    mem_arb_streak #(
        .MAX_STREAK (MAX_STREAK)
    ) u_streak (
        .i_clk     (Clk),
        .i_rst     (Rst),
        .i_grant_d (w_grant_d),
        .i_grant_i (w_grant_i),
        .i_ireq    (IReq),
        .o_at_max  (w_at_max)
    );

    assign w_force_i = w_at_max & IReq;
`else
    // MAX_STREAK has no effect in this build; keep it referenced.
    logic w_unused_max_streak;
    assign w_unused_max_streak = ^MAX_STREAK;
    assign w_force_i           = 1'b0;
`endif

    assign w_grant_d = w_idle & DReq & ~w_force_i;
    assign w_grant_i = w_idle & IReq & (~DReq | w_force_i);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_mreq   <= 1'b0;
            r_mwe    <= 1'b0;
            r_maddr  <= '0;
            r_mwdata <= '0;
            r_irdata <= '0;
            r_drdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state  <= BUSY_D;
                        r_mreq   <= 1'b1;
                        r_mwe    <= DWe;
                        r_maddr  <= DAddr;
                        r_mwdata <= DWdata;
                    end else if (w_grant_i) begin
                        r_state <= BUSY_I;
                        r_mreq  <= 1'b1;
                        r_mwe   <= 1'b0;
                        r_maddr <= IAddr;
                    end
                end
                BUSY_I: begin
                    if (MAck) begin
                        r_state  <= IDLE;
                        r_mreq   <= 1'b0;
                        r_irdata <= MRdata;
                    end
                end
                BUSY_D: begin
                    if (MAck) begin
                        r_state <= IDLE;
                        r_mreq  <= 1'b0;
                        r_mwe   <= 1'b0;
                        if (!r_mwe) begin
                            r_drdata <= MRdata;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_mreq  <= 1'b0;
                    r_mwe   <= 1'b0;
                end
            endcase
        end
    end

    assign MReq   = r_mreq;
    assign MWe    = r_mwe;
    assign MAddr  = r_maddr;
    assign MWdata = r_mwdata;
    assign IRdata = r_irdata;
    assign DRdata = r_drdata;
    assign IDone  = MAck & (r_state == BUSY_I);
    assign DDone  = MAck & (r_state == BUSY_D);

endmodule
